// File: rtl/npc_mem_pkg.sv
// rtl/npc_mem_pkg.sv - shared FSM encoding and constants for the NPC data-memory responder
package npc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
    localparam int          MASK_W            = 8;

endpackage

// File: rtl/npc_mem_array.sv
// rtl/npc_mem_array.sv - DEPTH x 64-bit word array, byte-masked synchronous write, combinational read
module npc_mem_array
    import npc_mem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [63:0]       wdata,
    input  logic [MASK_W-1:0] wmask,
    output logic [63:0]       rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/npc_mem_responder.sv
// rtl/npc_mem_responder.sv - single-outstanding load/store responder with configurable latency
// Optional NPC_MEM_RANDOM_DELAY_EN adds 0..3 LFSR-chosen cycles of extra latency per request.
module npc_mem_responder
    import npc_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_wen,
    input  logic [63:0]       req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = 5;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               rsp_valid_nxt;
    logic [63:0]        rsp_rdata_nxt;
    logic               rsp_err_nxt;

    logic [31:0]        addr_q;
    logic               wen_q;
    logic [63:0]        wdata_q;
    logic [MASK_W-1:0]  wmask_q;

    logic [31:0]        offset;
    logic [31:0]        word_idx;
    logic               addr_ok;
    logic               mem_we;
    logic [63:0]        mem_rdata;
    logic [CNT_W-1:0]   extra;

    assign req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
        end
    end

    // Unsigned wrap makes addresses below BASE_ADDR decode to huge, out-of-range indices.
    assign offset   = addr_q - BASE_ADDR;
    assign word_idx = offset >> 3;
    assign addr_ok  = (addr_q >= BASE_ADDR) && (word_idx < 32'(DEPTH)) && (addr_q[2:0] == 3'b000);
    assign mem_we   = (state == WAIT) && (cnt == '0) && wen_q && addr_ok && !rst;

`ifdef NPC_MEM_RANDOM_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra = {3'b000, lfsr[1:0]};
`else
    assign extra = '0;
`endif

    npc_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx[AW-1:0]),
        .wdata (wdata_q),
        .wmask (wmask_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(LATENCY - 1) + extra;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = !addr_ok;
                    rsp_rdata_nxt = (!wen_q && addr_ok) ? mem_rdata : 64'h0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/npc_mem_responder.md
Name:
npc_mem_responder

Overview:
- Memory-side responder for the NPC core's data port.
- Accepts one load/store request at a time over a valid/ready request channel.
- Models a configurable access latency, performs the access on an internal 64-bit-word array and returns the result over a valid/ready response channel.
- Stands in for data memory in simulation, and later serves as the slave end of the core's LSU bus.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH, 4096, number of 64-bit words (power of 2).
- LATENCY, 2, cycles from request handshake to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_wen  in  1  1 = store, 0 = load.
- req_wdata  in  64  store data.
- req_wmask  in  8  byte-enable for store; bit i enables wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  64  load data; 0 for stores and errors.
- rsp_err  out  1  address out of range or misaligned.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. req_ready=0 while rst is high. Array contents are not reset.
- FSM state IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr/wen/wdata/wmask, load cnt=LATENCY-1, go to WAIT.
- FSM state WAIT:
  - req_ready=0.
  - If cnt!=0, decrement.
  - If cnt==0, perform the access and go to RESP with rsp_valid=1 registered.
  - Result: a handshake at cycle T gives rsp_valid high from cycle T+LATENCY.
- FSM state RESP:
  - req_ready=0.
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready is high.
  - On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
  - The next request can therefore be accepted at the earliest one cycle after the response handshake.
- Address decode:
  - Word index = (addr-BASE_ADDR)>>3, 32-bit unsigned subtraction.
  - In range iff addr>=BASE_ADDR and index<DEPTH.
  - addr[2:0]!=0 means misaligned.
- Access rules:
  - Load in range: rsp_rdata=mem[index], rsp_err=0.
  - Store in range: write only the enabled bytes; rsp_rdata=0, rsp_err=0. wmask=0 is legal: no change, no error.
  - Out of range or misaligned: no array write, rsp_rdata=0, rsp_err=1.
- Boundaries:
  - Address BASE_ADDR+8*(DEPTH-1) is legal; BASE_ADDR+8*DEPTH is an error.
  - BASE_ADDR-8 wraps to a huge index and is an error.
  - Request inputs are ignored outside IDLE.
  - rst asserted in WAIT or RESP aborts: no pending write commits if rst is high in the commit cycle, and the FSM returns to IDLE.
- Ordering: strictly one outstanding request. A load after a store to the same word returns the new data.

Optional Feature:
- Macro: NPC_MEM_RANDOM_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on rst) advances every cycle.
  - On request accept, cnt=LATENCY-1+lfsr[1:0], adding 0..3 extra cycles.
  - All handshake rules are unchanged.
- Undefined: latency is exactly LATENCY and the LFSR is not present.

Decomposition:
- Shared package/header npc_mem_pkg: FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), default BASE_ADDR, and the mask width constant (8).
- One sub-module: npc_mem_array, a synchronous-write, combinational-read DEPTH x 64 array with byte mask. FSM, decode and latency counter stay in the top.

Test Plan:
- Store then load:
  - Store addr=0x8000_0010, wdata=64'h1122334455667788, wmask=8'hFF.
  - rsp_valid at T+2, rsp_err=0, rsp_rdata=0.
  - Load from the same address returns 64'h1122334455667788.
- Byte mask: after the above, store wdata=64'hFFFF_FFFF_FFFF_FFFF with wmask=8'h0F, then load. Expect 64'h11223344FFFFFFFF.
- Errors, each with rsp_err=1, rsp_rdata=0:
  - Load at 0x7FFF_FFF8.
  - Load at BASE+8*DEPTH.
  - Load at 0x8000_0004.
  - Then load 0x8000_0010 and confirm it is unchanged.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid rises. rsp_valid and rsp_rdata stay stable and req_ready=0.
  - Raise rsp_ready: handshake occurs, and req_ready=1 the next cycle.
- Reset mid-operation:
  - Assert rst for 1 cycle while in WAIT on a store to 0x8000_0020.
  - Then rsp_valid=0 and the FSM is in IDLE, and a load of 0x8000_0020 returns its prior value.
- Latency sweep and random delay:
  - LATENCY=1 and 15: rsp_valid exactly 1 and 15 cycles after the handshake.
  - With NPC_MEM_RANDOM_DELAY_EN: delay lies within LATENCY..LATENCY+3 over 200 requests, and no data mismatch against the reference model.
